// File: rtl/chunk_assembler_pkg.sv
// Shared defaults, derived sizes and state encoding for the chunk assembler.
package chunk_pkg;

   localparam int WORD_W_DEF      = 32;
   localparam int CHUNK_W_DEF     = 4;
   localparam int CHUNKS_PER_WORD = WORD_W_DEF / CHUNK_W_DEF;

   typedef enum logic {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } state_t;

   // Width of a counter that holds 0 .. n-1 (at least one bit).
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/chunk_assembler_if.sv
// Chunk input / word output handshake bundle plus sticky error flags.
interface chunk_assembler_if
   import chunk_pkg::*;
#(
   parameter int WORD_W  = WORD_W_DEF,
   parameter int CHUNK_W = CHUNK_W_DEF
);

   logic               chunk_valid;
   logic               chunk_sof;
   logic [CHUNK_W-1:0] data_chunk;
   logic               word_ready;
   logic               word_valid;
   logic [WORD_W-1:0]  word_data;
   logic               framing_err;
   logic               overflow_err;
   logic               err_clear;

   // Producer/consumer side: drives chunks, ready and error clear.
   modport master (
      output chunk_valid, chunk_sof, data_chunk, word_ready, err_clear,
      input  word_valid, word_data, framing_err, overflow_err
   );

   // Assembler side.
   modport slave (
      input  chunk_valid, chunk_sof, data_chunk, word_ready, err_clear,
      output word_valid, word_data, framing_err, overflow_err
   );

endinterface

// File: rtl/chunk_shift_reg.sv
// Partial-word shift register with chunk count. Holds up to N-1 chunks; the
// Nth chunk is combined combinationally into word_next.
module chunk_shift_reg #(
   parameter int WORD_W  = 32,
   parameter int CHUNK_W = 4,
   parameter int CNT_W   = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               shift,
   input  logic [CHUNK_W-1:0] data_in,
   output logic [CNT_W-1:0]   count,
   output logic [WORD_W-1:0]  word_next
);

   localparam int N    = WORD_W / CHUNK_W;
   localparam int PART = WORD_W - CHUNK_W;

   logic [PART-1:0]  part_q;
   logic [CNT_W-1:0] count_q;

   // Earlier chunks sit above the incoming one, so the first chunk ends up on top.
   assign word_next = {part_q, data_in};
   assign count     = count_q;

   // Load restarts the partial word; shift appends below and wraps after N chunks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         part_q  <= '0;
         count_q <= '0;
      end else if (load) begin
         part_q  <= PART'(data_in);
         count_q <= CNT_W'(1);
      end else if (shift) begin
         part_q  <= word_next[PART-1:0];
         count_q <= (count_q == CNT_W'(N - 1)) ? '0 : count_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/chunk_assembler.sv
// Assembles CHUNK_W-wide chunks (MS chunk first, framed by sof) into
// WORD_W-wide words, with a held output register and sticky error flags.
module chunk_assembler
   import chunk_pkg::*;
#(
   parameter int WORD_W  = WORD_W_DEF,
   parameter int CHUNK_W = CHUNK_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   chunk_assembler_if.slave bus
);

   localparam int N     = WORD_W / CHUNK_W;
   localparam int CNT_W = cnt_width(N);

   state_t             state_q, state_d;
   logic               load, shift, complete, frame_set;
   logic [CNT_W-1:0]   count;
   logic [WORD_W-1:0]  word_next;
   logic               word_valid_q;
   logic [WORD_W-1:0]  word_data_q;
   logic               framing_q, overflow_q;
   logic               handshake, drop;

   chunk_shift_reg #(
      .WORD_W  (WORD_W),
      .CHUNK_W (CHUNK_W),
      .CNT_W   (CNT_W)
   ) u_shift (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .shift     (shift),
      .data_in   (bus.data_chunk),
      .count     (count),
      .word_next (word_next)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state and per-cycle controls for the shift register and error flags.
   always_comb begin
      state_d   = state_q;
      load      = 1'b0;
      shift     = 1'b0;
      complete  = 1'b0;
      frame_set = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.chunk_valid) begin
               if (bus.chunk_sof) begin
                  load    = 1'b1;
                  state_d = COLLECT;
               end else begin
                  frame_set = 1'b1;
               end
            end
         end
         COLLECT: begin
            if (bus.chunk_valid) begin
               if (bus.chunk_sof) begin
                  frame_set = 1'b1;
                  load      = 1'b1;
               end else begin
                  shift = 1'b1;
                  if (count == CNT_W'(N - 1)) begin
                     complete = 1'b1;
                     state_d  = IDLE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign handshake = word_valid_q & bus.word_ready;
   assign drop      = complete & word_valid_q & ~bus.word_ready;

   // Output word register: accepts a completed word when empty or being drained.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_valid_q <= 1'b0;
         word_data_q  <= '0;
      end else if (complete && (!word_valid_q || bus.word_ready)) begin
         word_valid_q <= 1'b1;
         word_data_q  <= word_next;
      end else if (handshake) begin
         word_valid_q <= 1'b0;
      end
   end

   // Sticky error flags; a new error in the clear cycle keeps the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         framing_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         framing_q  <= frame_set | (framing_q  & ~bus.err_clear);
         overflow_q <= drop      | (overflow_q & ~bus.err_clear);
      end
   end

   assign bus.word_valid   = word_valid_q;
   assign bus.word_data    = word_data_q;
   assign bus.framing_err  = framing_q;
   assign bus.overflow_err = overflow_q;

endmodule

// File: tb/tb_chunk_assembler.sv
// Directed self-checking bench for chunk_assembler (32-bit word, 4-bit chunks).
module tb_chunk_assembler;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   chunk_assembler_if #(.WORD_W(32), .CHUNK_W(4)) bus ();

   chunk_assembler #(.WORD_W(32), .CHUNK_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running want done");
      $fatal(1, "timeout");
   end

   // One chunk presented for one cycle; returns at the following negedge.
   task automatic send(input logic [3:0] d, input logic sof);
      bus.chunk_valid = 1'b1;
      bus.chunk_sof   = sof;
      bus.data_chunk  = d;
      @(negedge clk);
      bus.chunk_valid = 1'b0;
      bus.chunk_sof   = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 8; i++) send(w[31-4*i -: 4], (i == 0));
   endtask

   task automatic pulse_clear();
      bus.err_clear = 1'b1;
      @(negedge clk);
      bus.err_clear = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      n_tests++; if (bus.word_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bus.word_valid); end
      n_tests++; if (bus.word_data !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h want 00000000", bus.word_data); end
      n_tests++; if (bus.framing_err !== 1'b0) begin n_fail++; $display("FAIL rst_framing: got %b want 0", bus.framing_err); end
      n_tests++; if (bus.overflow_err !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %b want 0", bus.overflow_err); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [3:0] seq [8] = '{4'h2, 4'h3, 4'h5, 4'h5, 4'h5, 4'h7, 4'h6, 4'h5};
      bus.word_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         send(seq[i], (i == 0));
         if (i < 7) begin
            n_tests++; if (bus.word_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid[%0d]: got %b want 0", i, bus.word_valid); end
         end
      end
      n_tests++; if (bus.word_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", bus.word_valid); end
      n_tests++; if (bus.word_data !== 32'h23555765) begin n_fail++; $display("FAIL basic_data: got %h want 23555765", bus.word_data); end
      @(negedge clk);
      n_tests++; if (bus.word_valid !== 1'b0) begin n_fail++; $display("FAIL basic_one_cycle: got %b want 0", bus.word_valid); end
      n_tests++; if (bus.framing_err !== 1'b0 || bus.overflow_err !== 1'b0) begin n_fail++; $display("FAIL basic_errs: got %b%b want 00", bus.framing_err, bus.overflow_err); end
   endtask

   task automatic test_idle_gaps();
      logic [3:0] seq [8] = '{4'h2, 4'h3, 4'h5, 4'h5, 4'h5, 4'h7, 4'h6, 4'h5};
      bus.word_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         send(seq[i], (i == 0));
         if (i < 7) begin
            repeat (3) @(negedge clk);
            n_tests++; if (bus.word_valid !== 1'b0) begin n_fail++; $display("FAIL gaps_early_valid[%0d]: got %b want 0", i, bus.word_valid); end
         end
      end
      n_tests++; if (bus.word_valid !== 1'b1) begin n_fail++; $display("FAIL gaps_valid: got %b want 1", bus.word_valid); end
      n_tests++; if (bus.word_data !== 32'h23555765) begin n_fail++; $display("FAIL gaps_data: got %h want 23555765", bus.word_data); end
      n_tests++; if (bus.framing_err !== 1'b0 || bus.overflow_err !== 1'b0) begin n_fail++; $display("FAIL gaps_errs: got %b%b want 00", bus.framing_err, bus.overflow_err); end
      @(negedge clk);
   endtask

   task automatic test_framing();
      bus.word_ready = 1'b1;
      send(4'h1, 1'b1);
      send(4'h2, 1'b0);
      send(4'h3, 1'b0);
      send(4'h4, 1'b0);
      n_tests++; if (bus.framing_err !== 1'b0) begin n_fail++; $display("FAIL frame_before: got %b want 0", bus.framing_err); end
      send_word(32'hABCDEF01);
      n_tests++; if (bus.framing_err !== 1'b1) begin n_fail++; $display("FAIL frame_err: got %b want 1", bus.framing_err); end
      n_tests++; if (bus.word_valid !== 1'b1) begin n_fail++; $display("FAIL frame_valid: got %b want 1", bus.word_valid); end
      n_tests++; if (bus.word_data !== 32'hABCDEF01) begin n_fail++; $display("FAIL frame_data: got %h want abcdef01", bus.word_data); end
      @(negedge clk);
      // Clear coinciding with a fresh framing error: error wins.
      bus.err_clear   = 1'b1;
      bus.chunk_valid = 1'b1;
      bus.chunk_sof   = 1'b0;
      bus.data_chunk  = 4'h9;
      @(negedge clk);
      bus.err_clear   = 1'b0;
      bus.chunk_valid = 1'b0;
      n_tests++; if (bus.framing_err !== 1'b1) begin n_fail++; $display("FAIL frame_clear_race: got %b want 1", bus.framing_err); end
      n_tests++; if (bus.word_valid !== 1'b0) begin n_fail++; $display("FAIL frame_discard: got %b want 0", bus.word_valid); end
      pulse_clear();
      n_tests++; if (bus.framing_err !== 1'b0) begin n_fail++; $display("FAIL frame_clear: got %b want 0", bus.framing_err); end
   endtask

   task automatic test_overflow();
      bus.word_ready = 1'b0;
      send_word(32'h12345678);
      n_tests++; if (bus.word_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_valid1: got %b want 1", bus.word_valid); end
      n_tests++; if (bus.word_data !== 32'h12345678) begin n_fail++; $display("FAIL ovf_data1: got %h want 12345678", bus.word_data); end
      send_word(32'h9ABCDEF0);
      n_tests++; if (bus.word_data !== 32'h12345678) begin n_fail++; $display("FAIL ovf_held: got %h want 12345678", bus.word_data); end
      n_tests++; if (bus.word_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_valid2: got %b want 1", bus.word_valid); end
      n_tests++; if (bus.overflow_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err: got %b want 1", bus.overflow_err); end
      bus.word_ready = 1'b1;
      @(negedge clk);
      n_tests++; if (bus.word_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drain: got %b want 0", bus.word_valid); end
      pulse_clear();
      n_tests++; if (bus.overflow_err !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", bus.overflow_err); end
      n_tests++; if (bus.framing_err !== 1'b0) begin n_fail++; $display("FAIL ovf_framing: got %b want 0", bus.framing_err); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] w2 = 32'h01234567;
      bus.word_ready = 1'b0;
      send_word(32'hCAFEBABE);
      n_tests++; if (bus.word_data !== 32'hCAFEBABE) begin n_fail++; $display("FAIL b2b_data1: got %h want cafebabe", bus.word_data); end
      for (int i = 0; i < 7; i++) send(w2[31-4*i -: 4], (i == 0));
      n_tests++; if (bus.word_valid !== 1'b1 || bus.word_data !== 32'hCAFEBABE) begin n_fail++; $display("FAIL b2b_hold: got %b/%h want 1/cafebabe", bus.word_valid, bus.word_data); end
      bus.word_ready = 1'b1;
      send(w2[3:0], 1'b0);
      n_tests++; if (bus.word_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid2: got %b want 1", bus.word_valid); end
      n_tests++; if (bus.word_data !== 32'h01234567) begin n_fail++; $display("FAIL b2b_data2: got %h want 01234567", bus.word_data); end
      n_tests++; if (bus.overflow_err !== 1'b0) begin n_fail++; $display("FAIL b2b_overflow: got %b want 0", bus.overflow_err); end
      @(negedge clk);
      n_tests++; if (bus.word_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", bus.word_valid); end
   endtask

   task automatic test_reset_mid_word();
      bus.word_ready = 1'b0;
      send(4'h5, 1'b0);
      n_tests++; if (bus.framing_err !== 1'b1) begin n_fail++; $display("FAIL idle_nosof: got %b want 1", bus.framing_err); end
      send_word(32'h89ABCDEF);
      send(4'hF, 1'b1);
      for (int i = 0; i < 4; i++) send(4'hF, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      n_tests++; if (bus.word_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_valid: got %b want 0", bus.word_valid); end
      n_tests++; if (bus.word_data !== 32'h0) begin n_fail++; $display("FAIL mrst_data: got %h want 00000000", bus.word_data); end
      n_tests++; if (bus.framing_err !== 1'b0 || bus.overflow_err !== 1'b0) begin n_fail++; $display("FAIL mrst_errs: got %b%b want 00", bus.framing_err, bus.overflow_err); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(4'h3, 1'b0);
      n_tests++; if (bus.framing_err !== 1'b1) begin n_fail++; $display("FAIL mrst_nosof: got %b want 1", bus.framing_err); end
      n_tests++; if (bus.word_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_novalid: got %b want 0", bus.word_valid); end
      pulse_clear();
      bus.word_ready = 1'b1;
      send_word(32'h2468ACE0);
      n_tests++; if (bus.word_valid !== 1'b1 || bus.word_data !== 32'h2468ACE0) begin n_fail++; $display("FAIL mrst_word: got %b/%h want 1/2468ace0", bus.word_valid, bus.word_data); end
      @(negedge clk);
   endtask

   initial begin
      n_tests         = 0;
      n_fail          = 0;
      bus.chunk_valid = 1'b0;
      bus.chunk_sof   = 1'b0;
      bus.data_chunk  = '0;
      bus.word_ready  = 1'b0;
      bus.err_clear   = 1'b0;
      rst_n           = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_idle_gaps();
      test_framing();
      test_overflow();
      test_back_to_back();
      test_reset_mid_word();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/chunk_assembler.md
CHUNK_ASSEMBLER -- requirements
Module: chunk_assembler

Interface
REQ-001 SHALL have parameter WORD_W, default 32, width of the assembled word.
REQ-002 SHALL have parameter CHUNK_W, default 4, width of one chunk; WORD_W SHALL be an integer multiple of CHUNK_W (N = WORD_W/CHUNK_W, 8 by default).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port chunk_valid  input  1  data_chunk is valid this cycle.
REQ-006 SHALL have port chunk_sof  input  1  qualifies the first chunk of a word; ignored when chunk_valid=0.
REQ-007 SHALL have port data_chunk  input  CHUNK_W  chunk payload, most-significant chunk first.
REQ-008 SHALL have port word_ready  input  1  downstream accepts word_data.
REQ-009 SHALL have port word_valid  output  1  word_data holds a complete word.
REQ-010 SHALL have port word_data  output  WORD_W  assembled word.
REQ-011 SHALL have port framing_err  output  1  sticky framing-violation flag.
REQ-012 SHALL have port overflow_err  output  1  sticky dropped-word flag.
REQ-013 SHALL have port err_clear  input  1  synchronous clear of both sticky flags.

Function
REQ-014 SHALL implement states IDLE (count=0, no partial word) and COLLECT (1..N-1 chunks held).
REQ-015 IDLE: chunk_valid&chunk_sof SHALL load the chunk as the top chunk, set count=1, and go to COLLECT.
REQ-016 IDLE: chunk_valid without chunk_sof SHALL discard the chunk and set framing_err.
REQ-017 COLLECT: chunk_valid without chunk_sof SHALL shift the chunk in below the previous chunks and increment count.
REQ-018 COLLECT: chunk_valid&chunk_sof SHALL set framing_err, discard the partial word, and restart with this chunk as count=1.
REQ-019 On the Nth chunk, the complete word SHALL transfer to the output register, and count SHALL wrap to 0 (IDLE); word_valid SHALL rise the cycle after the Nth chunk is sampled (latency 1).
REQ-020 Output register: word_valid SHALL stay high and word_data SHALL stay stable until word_valid&word_ready is sampled.
REQ-021 Collection of the next word SHALL proceed while the output is held (double buffer).
REQ-022 Completion while word_valid=1 and word_ready=0 SHALL drop the new word, keep the old word, and set overflow_err.
REQ-023 Completion in the same cycle as a handshake SHALL load the new word with word_valid remaining 1 and no error.
REQ-024 err_clear SHALL clear both flags; a new error in the same cycle SHALL win (flag stays 1).
REQ-025 chunk_valid=0 cycles SHALL leave count and the partial word unchanged (no timeout).

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, count=0, word_valid=0, word_data=0, framing_err=0, and overflow_err=0.
REQ-027 Reset mid-word SHALL discard the partial word and any held output word; the first chunk after release SHALL require chunk_sof.

Structure
REQ-028 Package chunk_pkg SHALL hold the WORD_W/CHUNK_W defaults, CHUNKS_PER_WORD, and the state enum (IDLE, COLLECT).
REQ-029 One sub-module, chunk_shift_reg (shift-in register plus count), SHALL be instantiated; handshake, state machine, and error logic SHALL remain in the top level.

Verification
REQ-030 Chunks 2,3,5,5,5,7,6,5 with sof on the first chunk and word_ready=1 -> word_valid for exactly 1 cycle, starting one cycle after the last chunk, with word_data=32'h23555765.
REQ-031 Same stream with 3 idle cycles between chunks -> same word, no errors.
REQ-032 Sof, then 3 chunks, then a new sof followed by 8 chunks of A..H -> framing_err=1, word_data=32'hA…H (hex ABCDEF01-style value from the second burst only).
REQ-033 word_ready=0 while two complete words are sent -> the first word is held, the second is dropped, and overflow_err=1; err_clear -> overflow_err=0.
REQ-034 A back-to-back word whose completion coincides with word_ready=1 -> both words are delivered in order, and overflow_err=0.
REQ-035 rst_n pulsed low after 5 chunks -> outputs are 0 during reset; afterwards a chunk without sof sets framing_err.
